// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mips_mem_pkg
//  Description : Shared types, constants and address-decode helpers for the
//                data-memory responder and its word RAM.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_mem_pkg;

    // Responder FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;
    // Latency counter width; holds up to LATENCY-1 = 14
    localparam int unsigned CNT_W      = 4;

    // Word index of a byte address relative to the RAM base (unsigned wrap
    // below the base is caught separately by is_err)
    function automatic logic [31:0] addr_to_index(input logic [31:0] addr,
                                                  input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return off >> $clog2(WORD_BYTES);
    endfunction

    // Misaligned, below the base, or past the last word
    function automatic logic is_err(input logic [31:0]  addr,
                                    input logic [31:0]  base,
                                    input int unsigned  words);
        return (addr[1:0] != 2'b00) ||
               (addr < base) ||
               (addr_to_index(addr, base) >= words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_word_ram.sv
`default_nettype none
// ============================================================================
//  Module      : mips_word_ram
//  Description : Single-port synchronous word RAM with per-byte write enables
//                and a registered read port. Contents are never reset.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_word_ram
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic                  we,
    input  logic [WORD_BYTES-1:0] be,
    input  logic [AW-1:0]         addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH];

    // One access per enabled cycle: byte-masked write or registered read.
    // The read register holds its value while en is low.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < WORD_BYTES; b++) begin
                    if (be[b]) begin
                        mem[addr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mips_data_mem_responder
//  Description : Data-memory responder for the core's load/store path. One
//                request at a time over valid/ready, fixed access latency,
//                byte-enabled stores, load data or error returned over a
//                valid/ready response channel.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned    AW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    // Captured request
    logic              cap_write;
    logic [31:0]       cap_addr;
    logic [31:0]       cap_wdata;
    logic [3:0]        cap_be;

    // Response is a successful load: RAM read data is routed out
    logic              resp_load_ok;

    logic              accept;
    logic              access;
    logic              cur_write;
    logic [31:0]       cur_addr;
    logic [31:0]       cur_wdata;
    logic [3:0]        cur_be;
    logic              cur_err;

    logic              ram_en;
    logic [AW-1:0]     ram_addr;
    logic [31:0]       ram_rdata;

    assign accept = req_valid && req_ready;

    // With LATENCY==1 the access edge is the acceptance edge itself, so the
    // live request feeds the RAM from IDLE; otherwise the captured copy does.
    assign cur_write = (state == ST_IDLE) ? req_write : cap_write;
    assign cur_addr  = (state == ST_IDLE) ? req_addr  : cap_addr;
    assign cur_wdata = (state == ST_IDLE) ? req_wdata : cap_wdata;
    assign cur_be    = (state == ST_IDLE) ? req_be    : cap_be;
    assign cur_err   = is_err(cur_addr, BASE_ADDR, MEM_WORDS);

    // The single edge that moves into RESP. Reset wins, so a store that
    // would commit on the same edge reset is asserted is dropped.
    assign access = !reset &&
                    (((state == ST_IDLE) && accept && (LATENCY == 1)) ||
                     ((state == ST_WAIT) && (cnt == CNT_ONE)));

    assign ram_en   = access && !cur_err;
    assign ram_addr = AW'(addr_to_index(cur_addr, BASE_ADDR));

    // RAM read register is only reloaded on an access edge, so it stays
    // stable for the whole RESP phase; stores and errors return zero.
    assign resp_rdata = (resp_valid && resp_load_ok) ? ram_rdata : 32'h0;

    mips_word_ram #(
        .DEPTH (MEM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .en    (ram_en),
        .we    (cur_write),
        .be    (cur_be),
        .addr  (ram_addr),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    // Request capture on acceptance; datapath only, no reset needed
    always_ff @(posedge clock) begin
        if ((state == ST_IDLE) && accept) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
        end
    end

    // Handshake FSM with latency counter and registered response flags
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_load_ok <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state        <= ST_RESP;
                            resp_valid   <= 1'b1;
                            resp_err     <= cur_err;
                            resp_load_ok <= !cur_write && !cur_err;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= LAT_M1;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state        <= ST_RESP;
                        resp_valid   <= 1'b1;
                        resp_err     <= cur_err;
                        resp_load_ok <= !cur_write && !cur_err;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state        <= ST_IDLE;
                        resp_valid   <= 1'b0;
                        resp_err     <= 1'b0;
                        resp_load_ok <= 1'b0;
                        req_ready    <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_data_mem_responder
//  Description : Directed self-checking bench for mips_data_mem_responder:
//                main LATENCY=2 instance plus LATENCY=1 and LATENCY=15
//                instances for timing and throughput.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_data_mem_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    // Main instance (LATENCY=2)
    logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_be;

    // LATENCY=1 instance
    logic        l1_req_valid, l1_req_ready, l1_resp_valid, l1_resp_ready, l1_resp_err;
    logic [31:0] l1_resp_rdata;

    // LATENCY=15 instance
    logic        l15_req_valid, l15_req_ready, l15_resp_valid, l15_resp_ready, l15_resp_err;
    logic [31:0] l15_resp_rdata;

    mips_data_mem_responder #(.MEM_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mips_data_mem_responder #(.MEM_WORDS(256), .LATENCY(1), .BASE_ADDR(32'h0)) dut_l1 (
        .clock(clock), .reset(reset),
        .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_write(1'b0),
        .req_addr(32'h0), .req_wdata(32'h0), .req_be(4'hF),
        .resp_valid(l1_resp_valid), .resp_ready(l1_resp_ready),
        .resp_rdata(l1_resp_rdata), .resp_err(l1_resp_err)
    );

    mips_data_mem_responder #(.MEM_WORDS(256), .LATENCY(15), .BASE_ADDR(32'h0)) dut_l15 (
        .clock(clock), .reset(reset),
        .req_valid(l15_req_valid), .req_ready(l15_req_ready), .req_write(1'b0),
        .req_addr(32'h0), .req_wdata(32'h0), .req_be(4'hF),
        .resp_valid(l15_resp_valid), .resp_ready(l15_resp_ready),
        .resp_rdata(l15_resp_rdata), .resp_err(l15_resp_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One full transaction on the main instance; hold = cycles resp_ready
    // stays low once resp_valid is seen
    task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold,
                       output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        guard     = 0;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_valid = 1'b1;
        while (!req_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!req_ready) check({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            step();
            lat++;
        end
        if (!resp_valid) check({tag, "_resp_timeout"}, 32'(resp_valid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            check({tag, "_hold"}, 32'(resp_valid), 32'd1);
            step();
        end
        resp_ready = 1'b1;
        rdata = resp_rdata;
        err   = resp_err;
        step();
        resp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          acc1, acc15, acc_cyc1, acc_cyc15, lat1, lat15;
    logic        seen_acc1, seen_acc15, seen_rsp1, seen_rsp15;

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        resp_ready = 1'b0;
        l1_req_valid = 1'b0; l1_resp_ready = 1'b0;
        l15_req_valid = 1'b0; l15_resp_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err",   32'(resp_err),   32'd0);
        check("rst_resp_rdata", resp_rdata,      32'd0);
        step();
        check("rst_req_ready",  32'(req_ready),  32'd1);

        // Latency 2, response held three cycles, ready again after handshake
        txn("t1_load0", 1'b0, 32'h0, 32'h0, 4'h0, 3, rd, er, lat);
        check("t1_latency", 32'(lat), 32'd2);
        check("t1_err",     32'(er),  32'd0);
        check("t1_req_ready_after", 32'(req_ready), 32'd1);

        // Full-word store then load
        txn("t2_store", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        check("t2_store_err",   32'(er), 32'd0);
        check("t2_store_rdata", rd,      32'd0);
        txn("t2_load", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        check("t2_load_rdata", rd,      32'hDEADBEEF);
        check("t2_load_err",   32'(er), 32'd0);

        // Partial store, bytes 0 and 2
        txn("t3_store", 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, rd, er, lat);
        txn("t3_load",  1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        check("t3_load_rdata", rd, 32'hDE22BE44);

        // be=0000 store is a clean no-op
        txn("t3_nop_store", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, rd, er, lat);
        check("t3_nop_err", 32'(er), 32'd0);
        txn("t3_nop_load", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        check("t3_nop_rdata", rd, 32'hDE22BE44);

        // Error cases
        txn("t4_misalign", 1'b0, 32'h13, 32'h0, 4'h0, 0, rd, er, lat);
        check("t4_misalign_err",   32'(er), 32'd1);
        check("t4_misalign_rdata", rd,      32'd0);
        txn("t4_oor_load", 1'b0, 32'h400, 32'h0, 4'h0, 0, rd, er, lat);
        check("t4_oor_load_err", 32'(er), 32'd1);
        txn("t4_w0_store", 1'b1, 32'h0, 32'h01234567, 4'hF, 0, rd, er, lat);
        txn("t4_last_store", 1'b1, 32'h3FC, 32'h89ABCDEF, 4'hF, 0, rd, er, lat);
        check("t4_last_store_err", 32'(er), 32'd0);
        txn("t4_oor_store", 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
        check("t4_oor_store_err", 32'(er), 32'd1);
        txn("t4_w0_load", 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
        check("t4_w0_unchanged", rd, 32'h01234567);
        txn("t4_last_load", 1'b0, 32'h3FC, 32'h0, 4'h0, 0, rd, er, lat);
        check("t4_last_unchanged", rd, 32'h89ABCDEF);
        txn("t4_w4_load", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        check("t4_w4_unchanged", rd, 32'hDE22BE44);

        // Reset during WAIT drops the store
        txn("t5_pre_store", 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 0, rd, er, lat);
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        req_valid = 1'b1;
        check("t5_ready_before", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        check("t5_in_wait", 32'(resp_valid), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("t5_rst_req_ready",  32'(req_ready),  32'd1);
        txn("t5_load", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
        check("t5_dropped_store", rd, 32'hA5A5A5A5);

        // Reset during RESP keeps the committed store
        req_write = 1'b1; req_addr = 32'h24; req_wdata = 32'h5A5A1234; req_be = 4'hF;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        check("t5_resp_reached", 32'(resp_valid), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_resp_dropped", 32'(resp_valid), 32'd0);
        txn("t5_load_commit", 1'b0, 32'h24, 32'h0, 4'h0, 0, rd, er, lat);
        check("t5_committed_store", rd, 32'h5A5A1234);

        // LATENCY=1 and LATENCY=15 timing with requests held continuously
        reset = 1'b1;
        step();
        reset = 1'b0;
        l1_req_valid = 1'b1;  l1_resp_ready = 1'b1;
        l15_req_valid = 1'b1; l15_resp_ready = 1'b1;
        acc1 = 0; acc15 = 0; acc_cyc1 = 0; acc_cyc15 = 0; lat1 = -1; lat15 = -1;
        seen_acc1 = 1'b0; seen_acc15 = 1'b0; seen_rsp1 = 1'b0; seen_rsp15 = 1'b0;
        for (int c = 0; c < 160; c++) begin
            if (l1_req_valid && l1_req_ready && c < 40) begin
                acc1++;
                if (!seen_acc1) begin acc_cyc1 = c; seen_acc1 = 1'b1; end
            end
            if (l15_req_valid && l15_req_ready) begin
                acc15++;
                if (!seen_acc15) begin acc_cyc15 = c; seen_acc15 = 1'b1; end
            end
            if (l1_resp_valid && seen_acc1 && !seen_rsp1) begin
                lat1 = c - acc_cyc1; seen_rsp1 = 1'b1;
            end
            if (l15_resp_valid && seen_acc15 && !seen_rsp15) begin
                lat15 = c - acc_cyc15; seen_rsp15 = 1'b1;
            end
            step();
        end
        l1_req_valid = 1'b0;
        l15_req_valid = 1'b0;
        check("t6_lat1",     32'(lat1),  32'd1);
        check("t6_lat15",    32'(lat15), 32'd15);
        check("t6_accepts1", 32'(acc1),  32'd20);
        check("t6_accepts15", 32'(acc15), 32'd10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
